// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the register file bank and its scoreboard.
package reg_file_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int DEPTH_DEF = 32;
   localparam int NREAD_MAX = 4;

   // Smallest w such that 2**w >= n.
   function automatic int addr_width(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// One pending bit per register: set by an issuing producer, cleared by the write that retires it.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en_i,
   input  logic [AW-1:0]    set_addr_i,
   input  logic             clr_en_i,
   input  logic [AW-1:0]    clr_addr_i,
   output logic [DEPTH-1:0] pending_o
);

   logic [DEPTH-1:0] pending_q;
   logic [DEPTH-1:0] pending_d;

   // Set is applied after clear so a new producer wins over the retiring write.
   always_comb begin
      pending_d = pending_q;
      if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
      if (set_en_i) pending_d[set_addr_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pending_q <= '0;
      else      pending_q <= pending_d;
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/reg_file_bank.sv
// Multi-read-port register file with optional zero register, write bypass and pending scoreboard.
module reg_file_bank
   import reg_file_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int AW       = addr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [AW-1:0]         wa,
   input  logic [XLEN-1:0]       wd,
   input  logic [NREAD*AW-1:0]   ra,
   output logic [NREAD*XLEN-1:0] rd,
   input  logic                  sb_set,
   input  logic [AW-1:0]         sb_addr,
   output logic [NREAD-1:0]      pend,
   output logic                  pend_any
);

   logic [XLEN-1:0]  mem_q [DEPTH];
   logic [DEPTH-1:0] pending;
   logic             wr_commit;
   logic             sb_set_ok;

   assign wr_commit = we && !((ZERO_REG != 0) && (wa == '0));
   assign sb_set_ok = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_commit) begin
         mem_q[wa] <= wd;
      end
   end

   reg_scoreboard #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .set_en_i   (sb_set_ok),
      .set_addr_i (sb_addr),
      .clr_en_i   (wr_commit),
      .clr_addr_i (wa),
      .pending_o  (pending)
   );

   // Forwarding also masks pending: the consumer already sees the producer's data.
   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [AW-1:0] ra_g;
      logic          fwd_g;
      logic          zero_g;

      assign ra_g   = ra[g*AW +: AW];
      assign fwd_g  = (BYPASS != 0) && we && (wa == ra_g);
      assign zero_g = (ZERO_REG != 0) && (ra_g == '0);
      assign rd[g*XLEN +: XLEN] = zero_g ? '0 : (fwd_g ? wd : mem_q[ra_g]);
      assign pend[g] = pending[ra_g] && !fwd_g;
   end

   assign pend_any = |pending;

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed and random checks of reg_file_bank (bypass and non-bypass builds) against an array model.
module tb_reg_file_bank;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [9:0]  ra;
   logic        sb_set;
   logic [4:0]  sb_addr;
   logic [63:0] rd_b, rd_n;
   logic [1:0]  pend_b, pend_n;
   logic        pa_b, pa_n;

   logic [31:0] mem_m  [32];
   logic        pend_m [32];

   int n_tests = 0;
   int n_fail  = 0;

   reg_file_bank #(.XLEN(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_byp (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
      .sb_set(sb_set), .sb_addr(sb_addr), .pend(pend_b), .pend_any(pa_b)
   );

   reg_file_bank #(.XLEN(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) u_dut_nob (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_n),
      .sb_set(sb_set), .sb_addr(sb_addr), .pend(pend_n), .pend_any(pa_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         mem_m[i]  = '0;
         pend_m[i] = 1'b0;
      end
   endtask

   function automatic logic [31:0] exp_rd(input bit byp, input int a);
      if (a == 0) return '0;
      if (byp && we && (int'(wa) == a)) return wd;
      return mem_m[a];
   endfunction

   function automatic logic exp_pend(input bit byp, input int a);
      if (byp && we && (int'(wa) == a)) return 1'b0;
      return pend_m[a];
   endfunction

   function automatic logic exp_any();
      logic r;
      r = 1'b0;
      for (int i = 0; i < 32; i++) r = r | pend_m[i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int a;
      for (int i = 0; i < 2; i++) begin
         a = int'(ra[i*5 +: 5]);
         chk($sformatf("%s/rd%0d_byp a=%0d", tag, i, a), rd_b[i*32 +: 32], exp_rd(1'b1, a));
         chk($sformatf("%s/rd%0d_nob a=%0d", tag, i, a), rd_n[i*32 +: 32], exp_rd(1'b0, a));
         chk($sformatf("%s/pend%0d_byp a=%0d", tag, i, a), 32'(pend_b[i]), 32'(exp_pend(1'b1, a)));
         chk($sformatf("%s/pend%0d_nob a=%0d", tag, i, a), 32'(pend_n[i]), 32'(exp_pend(1'b0, a)));
      end
      chk($sformatf("%s/pend_any_byp", tag), 32'(pa_b), 32'(exp_any()));
      chk($sformatf("%s/pend_any_nob", tag), 32'(pa_n), 32'(exp_any()));
   endtask

   // Model update: a committed write stores data and retires pending, then a set marks pending.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         if (we && wa != 5'd0) begin
            mem_m[wa]  = wd;
            pend_m[wa] = 1'b0;
         end
         if (sb_set && sb_addr != 5'd0) pend_m[sb_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic step(input string tag);
      @(negedge clk);
      check_all(tag);
      tick();
   endtask

   initial begin
      logic [4:0] a0, a1;
      rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0; sb_set = 1'b0; sb_addr = '0;
      model_reset();

      for (int a = 0; a < 32; a++) begin
         ra = {5'(31 - a), 5'(a)};
         @(negedge clk);
         check_all("reset_sweep");
      end

      // Write and set presented as reset releases must land on the first edge.
      rst = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'hCAFE_0003; sb_set = 1'b1; sb_addr = 5'd9;
      tick();
      we = 1'b0; sb_set = 1'b0; ra = {5'd9, 5'd3};
      step("post_reset");

      we = 1'b1; wa = 5'd15; wd = 32'hFFFF_FFFF; ra = '0;
      step("wr15");
      we = 1'b0; ra = {5'd0, 5'd15};
      step("rd15");

      we = 1'b1; wa = 5'd7; wd = 32'h1111_2222;
      step("wr7_old");
      we = 1'b1; wa = 5'd9; wd = 32'h0000_0009; sb_set = 1'b1; sb_addr = 5'd7;
      step("set7");
      sb_set = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5; ra = {5'd7, 5'd7};
      step("bypass7");
      we = 1'b0;
      step("after_bypass7");

      we = 1'b1; wa = 5'd0; wd = 32'h1234_5678; sb_set = 1'b1; sb_addr = 5'd0; ra = {5'd0, 5'd0};
      step("zero_wr");
      we = 1'b0; sb_set = 1'b0;
      step("zero_after");

      sb_set = 1'b1; sb_addr = 5'd5; ra = {5'd1, 5'd5};
      step("sb_set5");
      sb_set = 1'b0;
      step("sb_pend5");
      we = 1'b1; wa = 5'd5; wd = 32'h5555_0005; sb_set = 1'b1; sb_addr = 5'd5;
      step("sb_wr_and_set5");
      we = 1'b0; sb_set = 1'b0;
      step("sb_set_wins5");
      we = 1'b1; wa = 5'd5; wd = 32'h5555_0006;
      step("sb_wr5");
      we = 1'b0;
      step("sb_cleared5");

      for (int n = 0; n < 200; n++) begin
         we      = 1'($urandom_range(0, 1));
         wa      = 5'($urandom_range(0, 15));
         wd      = $urandom;
         sb_set  = 1'($urandom_range(0, 1));
         sb_addr = 5'($urandom_range(0, 15));
         a0      = 5'($urandom_range(0, 15));
         a1      = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 15));
         ra      = {a1, a0};
         step("random");
      end

      for (int a = 1; a < 32; a++) begin
         we = 1'b1; wa = 5'(a); wd = $urandom | 32'h1;
         sb_set = 1'b1; sb_addr = 5'((a + 7) % 32);
         ra = {5'(a - 1), 5'(a)};
         step("load");
      end
      we = 1'b0; sb_set = 1'b0; ra = {5'd30, 5'd31};
      @(negedge clk);
      check_all("pre_async");
      tick();

      // 3-unit reset pulse entirely between edges.
      ra = {5'd2, 5'd1};
      #1 rst = 1'b0;
      model_reset();
      #1 check_all("async_a");
      ra = {5'd17, 5'd16};
      #1 check_all("async_b");
      ra = {5'd31, 5'd30};
      #1 check_all("async_c");
      rst = 1'b1;

      for (int n = 0; n < 20; n++) begin
         we      = 1'($urandom_range(0, 1));
         wa      = 5'($urandom_range(0, 31));
         wd      = $urandom;
         sb_set  = 1'($urandom_range(0, 1));
         sb_addr = 5'($urandom_range(0, 31));
         ra      = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
         step("post_async");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_bank.md
REG_FILE_BANK -- requirements
Module: reg_file_bank

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst; rst SHALL be asserted at 0.
REQ-002 Parameter XLEN, default 32: data width in bits.
REQ-003 Parameter DEPTH, default 32: number of registers; it SHALL be a power of two, and AW = log2(DEPTH).
REQ-004 Parameter NREAD, default 2: number of read ports, legal range 1..4.
REQ-005 Parameter ZERO_REG, default 1: when 1, register 0 reads 0 and ignores writes.
REQ-006 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to matching read ports.
REQ-007 Port clk, input, 1: rising-edge clock.
REQ-008 Port rst, input, 1: asynchronous active-low reset.
REQ-009 Port we, input, 1: write enable.
REQ-010 Port wa, input, AW: write address.
REQ-011 Port wd, input, XLEN: write data.
REQ-012 Port ra, input, NREAD*AW: read addresses; port i occupies bits [i*AW +: AW].
REQ-013 Port rd, output, NREAD*XLEN: read data; port i occupies bits [i*XLEN +: XLEN].
REQ-014 Port sb_set, input, 1: mark register sb_addr as pending, i.e. an in-flight producer.
REQ-015 Port sb_addr, input, AW: scoreboard set address.
REQ-016 Port pend, output, NREAD: bit i is the pending status of ra[i].
REQ-017 Port pend_any, output, 1: OR-reduction of all pending bits.

Function
REQ-018 Writes SHALL commit on the rising clk edge when we=1 and rst=1; the write latency is 1 cycle.
REQ-019 When ZERO_REG=1, a write to address 0 SHALL be discarded, and a read of address 0 SHALL return 0 regardless of any bypass.
REQ-020 Reads SHALL be combinational from ra, with zero-cycle latency.
REQ-021 When BYPASS=1 and we=1 and wa==ra[i] (and the address is not the discarded zero register), rd[i] SHALL equal wd in the same cycle; when BYPASS=0, rd[i] SHALL return the stored value.
REQ-022 Multiple read ports addressing the same register SHALL all return identical data.
REQ-023 The scoreboard SHALL hold one pending bit per register.
REQ-024 On a clock edge with sb_set=1, pending[sb_addr] SHALL be set.
REQ-025 On a clock edge with a committed write, pending[wa] SHALL be cleared.
REQ-026 When sb_set and a write target the same address on the same edge, set SHALL win.
REQ-027 The pending bit of register 0 SHALL never be set when ZERO_REG=1.
REQ-028 pend[i] SHALL be pending[ra[i]] from registered state, except that it SHALL be forced to 0 when BYPASS=1, we=1 and wa==ra[i], because the data is forwarded.
REQ-029 pend_any SHALL reflect registered state only.
REQ-030 Simultaneous sb_set and writes to different addresses SHALL both take effect on the same edge.

Reset
REQ-031 While rst=0, all registers SHALL be 0 and all pending bits SHALL be 0, asynchronously, with no clock required.
REQ-032 Any write or sb_set present in the cycle when rst deasserts SHALL be honoured at the first rising edge after deassertion.
REQ-033 Reset asserted mid-operation SHALL discard all stored data and pending state immediately.
REQ-034 During reset, rd SHALL read 0, unless BYPASS forwarding applies.
REQ-035 During reset, pend and pend_any SHALL read 0.

Structure
REQ-036 Package reg_file_pkg SHALL hold the XLEN and DEPTH defaults, the log2 address-width helper, and the NREAD limit constant.
REQ-037 The scoreboard SHALL be a sub-module, reg_scoreboard, with inputs DEPTH, clk, rst, set/addr and clear/addr, and output the pending vector.
REQ-038 The data array and read/bypass multiplexing SHALL reside in reg_file_bank.

Verification
REQ-039 Reset check: assert rst=0, then sweep ra over all addresses -> every rd=0 and pend=0.
REQ-040 Write/read check: write 0xFFFFFFFF to address 15, then read ra0=15 next cycle -> rd0=0xFFFFFFFF.
REQ-041 Bypass check: same cycle we=1, wa=7, wd=0xA5A5A5A5, ra0=ra1=7 -> rd0=rd1=0xA5A5A5A5 and pend=0; repeat with BYPASS=0 -> old value is returned.
REQ-042 Zero-register check: write 0x12345678 to address 0, together with sb_set on address 0 -> rd reads 0 and pend_any stays 0.
REQ-043 Scoreboard check: sb_set on address 5, then the next cycle ra0=5 -> pend[0]=1; then write address 5 together with sb_set on address 5 -> pend stays 1; then write address 5 alone -> pend clears.
REQ-044 Async-reset check: load addresses 1..31, then pulse rst=0 for 3 ns between clock edges -> all reads return 0 immediately.
